// File: rtl/adder_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : adder_share_arbiter
// Description : Round-robin arbiter/sequencer that time-shares one external
//               combinational adder among NUM_REQ requesters. One operation
//               is in flight at a time: accept -> settle -> respond.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
  input  logic [NUM_REQ-1:0]       req_cin_i,
  output logic [WIDTH-1:0]         add_a_o,
  output logic [WIDTH-1:0]         add_b_o,
  output logic                     add_cin_o,
  input  logic [WIDTH-1:0]         add_sum_i,
  input  logic                     add_overflow_i,
  output logic                     resp_valid_o,
  input  logic                     resp_ready_i,
  output logic [ID_W-1:0]          resp_id_o,
  output logic [WIDTH-1:0]         resp_sum_o,
  output logic                     resp_overflow_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cin_q, cin_d;
  logic             rv_q, rv_d;
  logic [ID_W-1:0]  rid_q, rid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;

  logic             grant_any;
  logic [ID_W-1:0]  grant_id;
  logic [WIDTH-1:0] req_a_arr [NUM_REQ];
  logic [WIDTH-1:0] req_b_arr [NUM_REQ];

  // Unpack the flat operand buses into per-requester lanes.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign req_a_arr[gi] = req_a_i[gi*WIDTH +: WIDTH];
    assign req_b_arr[gi] = req_b_i[gi*WIDTH +: WIDTH];
  end

  // Round-robin scan: first valid requester at or after the pointer, wrapping.
  always_comb begin
    logic [ID_W:0]   cand;
    logic [ID_W-1:0] idx;
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      idx = cand[ID_W-1:0];
      if (!grant_any && req_valid_i[idx]) begin
        grant_any = 1'b1;
        grant_id  = idx;
      end
    end
  end

  // Next-state, operand capture and handshake decode for the sequencer.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    rv_d        = rv_q;
    rid_d       = rid_q;
    sum_d       = sum_q;
    ovf_d       = ovf_q;
    req_ready_o = '0;
    case (state_q)
      S_IDLE: begin
        // Ready is suppressed while reset is held so nothing is handed off.
        if (grant_any && rst_n) begin
          req_ready_o[grant_id] = 1'b1;
          a_d     = req_a_arr[grant_id];
          b_d     = req_b_arr[grant_id];
          cin_d   = req_cin_i[grant_id];
          id_d    = grant_id;
          ptr_d   = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Operands have been on the adder for a full cycle; capture result.
        sum_d   = add_sum_i;
        ovf_d   = add_overflow_i;
        rid_d   = id_q;
        rv_d    = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready_i) begin
          rv_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      rv_q    <= 1'b0;
      rid_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      rv_q    <= rv_d;
      rid_q   <= rid_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  assign add_a_o         = a_q;
  assign add_b_o         = b_q;
  assign add_cin_o       = cin_q;
  assign resp_valid_o    = rv_q;
  assign resp_id_o       = rid_q;
  assign resp_sum_o      = sum_q;
  assign resp_overflow_o = ovf_q;

endmodule
`default_nettype wire
